// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: word width, NOP encoding and stall counter width.
package cpu_pipe_pkg;

    localparam int WORD_W      = 32;
    localparam int STALL_CNT_W = 32;

    typedef logic [WORD_W-1:0] pipe_word_t;

    localparam pipe_word_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+data holding register. Clear drops the valid bit but keeps the data,
// so a squashed slot still shows its last payload.
module pipe_skid_slot
    import cpu_pipe_pkg::*;
#(
    parameter int               WIDTH       = WORD_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= 1'b0;
            data  <= RESET_VALUE;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline register with valid/ready handshake, a one-entry skid buffer and flush.
// Define PIPE_STAGE_REG_PERF_EN to enable the saturating downstream-stall counter.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] perf_stall_cnt
);

    // Handshake: a beat moves on a CLK edge where valid && ready are both 1 on that side.
    // in_ready is the inverted skid valid flop, so it never depends on out_ready.
    logic             main_valid, skid_valid;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             accept_in, drain;
    logic             main_load, main_clear, skid_load, skid_clear;
    logic [WIDTH-1:0] main_load_data;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign accept_in = in_valid && in_ready;
    assign drain     = !main_valid || out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_load_data = skid_valid ? skid_data : in_data;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (drain) begin
            // The skid beat is older than anything upstream, so it goes first.
            if (skid_valid) begin
                main_load  = 1'b1;
                skid_clear = 1'b1;
            end else if (accept_in) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (accept_in) begin
            skid_load = 1'b1;
        end
    end

    pipe_skid_slot #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (main_load),
        .clear    (main_clear),
        .load_data(main_load_data),
        .valid    (main_valid),
        .data     (main_data)
    );

    pipe_skid_slot #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (skid_load),
        .clear    (skid_clear),
        .load_data(in_data),
        .valid    (skid_valid),
        .data     (skid_data)
    );

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
